decoder_scan_sequencer: RTL and testbench
=========================================

// Module: decoder_scan_sequencer
// PURPOSE
//   Upstream driver for the 4-to-16 decoder stage. Steps a 4-bit channel index
//   over a programmable mask of 16 channels and raises an enable for a set dwell.
//   Inserts blanking (enable low) around every index change so the decoder's
//   one-hot output never glitches between channels.
//   Single-pass or continuous scanning; start/stop control via pulses.
// PARAMETERS
//   SEL_W        4   width of binary_out; channel count NUM_CH = 2**SEL_W = 16
//   DWELL_W      8   width of dwell input (cycles per channel)
//   BLANK_CYCLES 2   enable-low cycles before each channel drive; legal >= 1
// PORTS
//   clk          in   1        single clock, rising edge
//   reset_n      in   1        asynchronous active-low reset
//   start        in   1        pulse; begin scan (sampled only in IDLE)
//   stop         in   1        pulse; request graceful halt
//   continuous   in   1        1 = wrap and rescan, 0 = single pass; latched at start
//   dwell        in   DWELL_W  enable-high cycles per channel; 0 treated as 1; latched at start
//   chan_mask    in   NUM_CH   bit i = 1 visits channel i; latched at start and at each wrap
//   binary_out   out  SEL_W    channel index to the decoder
//   enable_out   out  1        decoder enable
//   chan_strobe  out  1        1-cycle pulse on first enable-high cycle of each channel
//   pass_done    out  1        1-cycle pulse on last DRIVE cycle of highest masked channel
//   busy         out  1        high in any state other than IDLE
// BEHAVIOUR
//   Reset (async, immediate, also mid-scan): state=IDLE; binary_out=0,
//     enable_out=0, chan_strobe=0, pass_done=0, busy=0; stop_pending cleared.
//   All outputs registered. States: IDLE, BLANK, DRIVE.
//   IDLE: start=1 and latched mask!=0 -> BLANK, idx = lowest set mask bit.
//     start with mask==0 -> stay IDLE, no pulses. start and stop in same cycle:
//     stop wins, start ignored. start while busy is ignored.
//   BLANK: binary_out=idx from first BLANK cycle, enable_out=0, lasts
//     BLANK_CYCLES cycles, then -> DRIVE.
//   DRIVE: enable_out=1 for max(dwell,1) cycles; chan_strobe on first of them.
//   End of DRIVE:
//     - stop_pending -> IDLE (no pass_done)
//     - else next set bit strictly above idx exists -> BLANK with that idx
//     - else pass_done pulses (same cycle); continuous=1 -> re-latch mask,
//       BLANK with lowest set bit (new mask==0 -> IDLE); continuous=0 -> IDLE
//   Latency: start sampled at edge N -> binary_out valid, busy=1 at N+1;
//     enable_out rises at N+1+BLANK_CYCLES.
//   stop: in DRIVE or BLANK sets stop_pending; in BLANK -> IDLE next cycle,
//     enable stays low; in IDLE ignored.
//   Single-bit mask in continuous mode: same channel, BLANK between each dwell.
//   binary_out holds last index in IDLE; enable_out never high outside DRIVE.
//   Dwell counter DWELL_W bits, counts down, no wrap possible.
// STRUCTURE
//   Package decoder_scan_pkg: SEL_W, NUM_CH, state encoding (IDLE/BLANK/DRIVE).
//   Sub-module decoder_scan_next_chan: combinational; inputs mask, idx;
//     outputs next_idx (lowest set bit > idx), found, first_idx (lowest set bit).
// TESTING
//   mask=16'h0005, dwell=3, continuous=0, start -> ch0 enable 3 cycles,
//     blank 2, ch2 enable 3; pass_done with last ch2 cycle; busy low after.
//   mask=16'hFFFF, dwell=0, continuous=1 -> 1-cycle dwell each ch 0..15;
//     pass_done every 48 cycles; wraps to ch0.
//   mask=16'h8001, stop on 2nd DRIVE cycle of ch0 (dwell=4) -> ch0 completes
//     4 cycles, then IDLE; no pass_done; ch15 never driven.
//   start with mask=0 -> busy stays 0, enable_out never rises.
//   Assert reset_n low mid-DRIVE -> enable_out=0, binary_out=0 same cycle
//     (async); after release, no activity until new start.
//   Assertions: enable_out high only in DRIVE; binary_out stable while
//     enable_out=1; chan_strobe count equals mask popcount per pass.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
// Shared constants and state encoding for the decoder scan sequencer.
package decoder_scan_pkg;

    localparam int SEL_W  = 4;
    localparam int NUM_CH = 2 ** SEL_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/decoder_scan_next_chan.sv
// Finds the lowest set mask bit above a given index, plus the lowest set bit overall.
module decoder_scan_next_chan
    import decoder_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  idx,
    output logic [SEL_W-1:0]  next_idx,
    output logic              found,
    output logic [SEL_W-1:0]  first_idx
);

    // Scanning from the top down lets the lowest qualifying bit win.
    always_comb begin
        next_idx  = '0;
        found     = 1'b0;
        first_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_idx = SEL_W'(i);
                if (i > int'(idx)) begin
                    next_idx = SEL_W'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps a channel index over a programmable mask, driving the decoder enable for a
// set dwell with blanking around every index change so the one-hot output never glitches.
module decoder_scan_sequencer
    import decoder_scan_pkg::*;
#(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  chan_mask,
    output logic [SEL_W-1:0]   binary_out,
    output logic               enable_out,
    output logic               chan_strobe,
    output logic               pass_done,
    output logic               busy
);

    localparam logic [DWELL_W-1:0] BLANK_LOAD = DWELL_W'(BLANK_CYCLES - 1);

    scan_state_e        state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [NUM_CH-1:0]  mask_q, mask_d, mask_sel;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d, drive_load;
    logic               cont_q, cont_d;
    logic               stop_pending_q, stop_pending_d;
    logic               last_chan_q, last_chan_d;
    logic               enable_q, enable_d;
    logic               strobe_q, strobe_d;
    logic               pass_done_q, pass_done_d;
    logic               stop_eff, found;
    logic [SEL_W-1:0]   next_idx, first_idx;

    // The finder looks at the live mask when a fresh pass may begin (start or wrap),
    // otherwise at the mask latched for the current pass.
    assign mask_sel   = (state_q == ST_IDLE || (state_q == ST_DRIVE && last_chan_q)) ?
                        chan_mask : mask_q;
    assign drive_load = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
    assign stop_eff   = stop_pending_q | stop;

    decoder_scan_next_chan u_next_chan (
        .mask      (mask_sel),
        .idx       (idx_q),
        .next_idx  (next_idx),
        .found     (found),
        .first_idx (first_idx)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        mask_d         = mask_q;
        dwell_d        = dwell_q;
        cont_d         = cont_q;
        stop_pending_d = stop_pending_q;
        cnt_d          = cnt_q;
        last_chan_d    = last_chan_q;
        case (state_q)
            ST_IDLE: begin
                stop_pending_d = 1'b0;
                if (start && !stop && chan_mask != '0) begin
                    state_d = ST_BLANK;
                    idx_d   = first_idx;
                    mask_d  = chan_mask;
                    dwell_d = dwell;
                    cont_d  = continuous;
                    cnt_d   = BLANK_LOAD;
                end
            end
            ST_BLANK: begin
                if (stop_eff) begin
                    state_d        = ST_IDLE;
                    stop_pending_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d     = ST_DRIVE;
                    cnt_d       = drive_load;
                    last_chan_d = !found;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DRIVE: begin
                stop_pending_d = stop_eff;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (stop_eff) begin
                    state_d        = ST_IDLE;
                    stop_pending_d = 1'b0;
                end else if (!last_chan_q) begin
                    state_d = ST_BLANK;
                    idx_d   = next_idx;
                    cnt_d   = BLANK_LOAD;
                end else if (cont_q && chan_mask != '0) begin
                    state_d = ST_BLANK;
                    idx_d   = first_idx;
                    mask_d  = chan_mask;
                    cnt_d   = BLANK_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // pass_done is registered, so it is decided on entry to the final DRIVE cycle;
        // a stop arriving during that very cycle still ends the scan but cannot recall it.
        enable_d    = (state_d == ST_DRIVE);
        strobe_d    = (state_d == ST_DRIVE) && (state_q != ST_DRIVE);
        pass_done_d = (state_d == ST_DRIVE) && (cnt_d == '0) && last_chan_d && !stop_pending_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            mask_q         <= '0;
            dwell_q        <= '0;
            cont_q         <= 1'b0;
            stop_pending_q <= 1'b0;
            cnt_q          <= '0;
            last_chan_q    <= 1'b0;
            enable_q       <= 1'b0;
            strobe_q       <= 1'b0;
            pass_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            mask_q         <= mask_d;
            dwell_q        <= dwell_d;
            cont_q         <= cont_d;
            stop_pending_q <= stop_pending_d;
            cnt_q          <= cnt_d;
            last_chan_q    <= last_chan_d;
            enable_q       <= enable_d;
            strobe_q       <= strobe_d;
            pass_done_q    <= pass_done_d;
        end
    end

    assign binary_out  = idx_q;
    assign enable_out  = enable_q;
    assign chan_strobe = strobe_q;
    assign pass_done   = pass_done_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench: a cycle-trace model expands each pass into per-cycle records
// that every DUT cycle is compared against, plus vector tables and corner sequences.
module tb_decoder_scan_sequencer;

    localparam int DWELL_W      = 8;
    localparam int BLANK_CYCLES = 2;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               continuous = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [15:0]        chan_mask = '0;
    logic [3:0]         binary_out;
    logic               enable_out, chan_strobe, pass_done, busy;

    decoder_scan_sequencer #(.DWELL_W(DWELL_W), .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .dwell       (dwell),
        .chan_mask   (chan_mask),
        .binary_out  (binary_out),
        .enable_out  (enable_out),
        .chan_strobe (chan_strobe),
        .pass_done   (pass_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] idx;
        logic       en;
        logic       strobe;
        logic       pd;
        logic       busy;
        logic       wrap;
    } rec_t;

    typedef struct {
        logic [15:0] mask;
        logic [7:0]  dwell;
        logic        cont;
        logic        stop_with_start;
        int          run;
        int          exp_stb;
        int          exp_en;
        int          exp_pd;
        logic        exp_busy;
    } vec_t;

    rec_t       q[$];
    rec_t       cur;
    logic [7:0] dwell_lat;
    logic       cont_lat;
    int         pass_pop;
    int         errors = 0;
    int         checks = 0;
    int         en_cnt, stb_cnt, pd_cnt, cycle_no, pass_stb;
    logic       ch15_driven, prev_en;
    logic [3:0] prev_bin;

    function automatic rec_t idle_rec(input logic [3:0] i);
        rec_t r;
        r.idx = i; r.en = 1'b0; r.strobe = 1'b0; r.pd = 1'b0; r.busy = 1'b0; r.wrap = 1'b0;
        return r;
    endfunction

    // One pass = for each set bit in ascending order: blanking cycles then dwell cycles.
    task automatic gen_pass(input logic [15:0] m);
        int   dd;
        rec_t r;
        logic last;
        dd = (dwell_lat == 8'd0) ? 1 : int'(dwell_lat);
        pass_pop = $countones(m);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                last = ((m >> (i + 1)) == 16'h0);
                for (int b = 0; b < BLANK_CYCLES; b++) begin
                    r = idle_rec(4'(i));
                    r.busy = 1'b1;
                    q.push_back(r);
                end
                for (int j = 0; j < dd; j++) begin
                    r = idle_rec(4'(i));
                    r.busy   = 1'b1;
                    r.en     = 1'b1;
                    r.strobe = (j == 0);
                    r.pd     = last && (j == dd - 1);
                    r.wrap   = cont_lat && last && (j == dd - 1);
                    q.push_back(r);
                end
            end
        end
    endtask

    task automatic model_edge();
        rec_t keep[$];
        rec_t r;
        int   n;
        if (!reset_n) begin
            q.delete();
            cur = idle_rec(4'd0);
            return;
        end
        if (cur.busy && stop) begin
            if (!cur.en) begin
                q.delete();
            end else begin
                n = 0;
                while (n < q.size() && q[n].en && q[n].idx == cur.idx) n++;
                for (int k = 0; k < n; k++) begin
                    r = q[k];
                    r.pd = 1'b0;
                    r.wrap = 1'b0;
                    keep.push_back(r);
                end
                q = keep;
            end
        end
        if (q.size() == 0) begin
            if (cur.busy) begin
                if (cur.wrap && !stop && chan_mask != 16'h0) gen_pass(chan_mask);
            end else if (start && !stop && chan_mask != 16'h0) begin
                dwell_lat = dwell;
                cont_lat  = continuous;
                gen_pass(chan_mask);
            end
        end
        if (q.size() != 0) cur = q.pop_front();
        else cur = idle_rec(cur.idx);
    endtask

    task automatic check_cycle();
        cycle_no++;
        checks++;
        if (binary_out !== cur.idx || enable_out !== cur.en || chan_strobe !== cur.strobe ||
            pass_done !== cur.pd || busy !== cur.busy) begin
            errors++;
            $display("[TB] FAIL trace cycle %0d: got bin=%0d en=%b stb=%b pd=%b busy=%b, want bin=%0d en=%b stb=%b pd=%b busy=%b",
                     cycle_no, binary_out, enable_out, chan_strobe, pass_done, busy,
                     cur.idx, cur.en, cur.strobe, cur.pd, cur.busy);
        end
        if (enable_out === 1'b1 && prev_en === 1'b1) begin
            checks++;
            if (binary_out !== prev_bin) begin
                errors++;
                $display("[TB] FAIL index_stable cycle %0d: got %0d while enabled, want %0d", cycle_no, binary_out, prev_bin);
            end
        end
        if (chan_strobe === 1'b1) pass_stb++;
        if (pass_done === 1'b1) begin
            checks++;
            if (pass_stb != pass_pop) begin
                errors++;
                $display("[TB] FAIL strobes_per_pass cycle %0d: got %0d, want %0d", cycle_no, pass_stb, pass_pop);
            end
            pass_stb = 0;
        end
        if (busy !== 1'b1) pass_stb = 0;
        en_cnt  += int'(enable_out === 1'b1);
        stb_cnt += int'(chan_strobe === 1'b1);
        pd_cnt  += int'(pass_done === 1'b1);
        if (enable_out === 1'b1 && binary_out == 4'd15) ch15_driven = 1'b1;
        prev_en  = enable_out;
        prev_bin = binary_out;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic cmp_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic clear_counts();
        en_cnt = 0; stb_cnt = 0; pd_cnt = 0; ch15_driven = 1'b0;
    endtask

    task automatic drain();
        int n;
        start = 1'b0;
        stop  = 1'b1;
        step();
        stop = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        cmp_int("drain_idle", int'(busy === 1'b1), 0);
    endtask

    task automatic wait_enable(input string name);
        int n;
        n = 0;
        while (enable_out !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        cmp_int(name, int'(enable_out === 1'b1), 1);
    endtask

    function automatic logic [15:0] rand_mask();
        case ($urandom_range(0, 3))
            0:       return 16'h0;
            1:       return 16'h1 << $urandom_range(0, 15);
            2:       return 16'($urandom) & 16'($urandom) & 16'($urandom);
            default: return 16'($urandom);
        endcase
    endfunction

    vec_t vecs[$];

    initial begin
        cur = idle_rec(4'd0);
        dwell_lat = '0; cont_lat = 1'b0; pass_pop = 0; pass_stb = 0; cycle_no = 0;
        prev_en = 1'b0; prev_bin = '0;
        clear_counts();

        //            mask      dwell cont  s+s  run  stb en  pd  busy
        vecs.push_back('{16'h0005, 8'd3, 1'b0, 1'b0, 20,  2,  6,  1, 1'b0});
        vecs.push_back('{16'hFFFF, 8'd0, 1'b1, 1'b0, 96, 32, 32,  2, 1'b1});
        vecs.push_back('{16'h0000, 8'd5, 1'b1, 1'b0, 10,  0,  0,  0, 1'b0});
        vecs.push_back('{16'h8000, 8'd0, 1'b0, 1'b0, 10,  1,  1,  1, 1'b0});
        vecs.push_back('{16'h00F0, 8'd2, 1'b0, 1'b0, 20,  4,  8,  1, 1'b0});
        vecs.push_back('{16'h0001, 8'd1, 1'b1, 1'b0, 30, 10, 10, 10, 1'b1});
        vecs.push_back('{16'h0005, 8'd3, 1'b0, 1'b1, 10,  0,  0,  0, 1'b0});
        vecs.push_back('{16'h8001, 8'd2, 1'b0, 1'b0, 12,  2,  4,  1, 1'b0});

        repeat (2) step();
        cmp_int("reset_state", int'({binary_out, enable_out, chan_strobe, pass_done, busy}), 0);
        reset_n = 1'b1;
        repeat (2) step();

        foreach (vecs[v]) begin
            drain();
            clear_counts();
            chan_mask  = vecs[v].mask;
            dwell      = vecs[v].dwell;
            continuous = vecs[v].cont;
            start      = 1'b1;
            stop       = vecs[v].stop_with_start;
            step();
            start = 1'b0;
            stop  = 1'b0;
            repeat (vecs[v].run - 1) step();
            cmp_int($sformatf("vec%0d_strobes", v), stb_cnt, vecs[v].exp_stb);
            cmp_int($sformatf("vec%0d_enable_cycles", v), en_cnt, vecs[v].exp_en);
            cmp_int($sformatf("vec%0d_pass_done", v), pd_cnt, vecs[v].exp_pd);
            cmp_int($sformatf("vec%0d_busy_end", v), int'(busy === 1'b1), int'(vecs[v].exp_busy));
        end

        // Stop during the second DRIVE cycle of ch0: ch0 finishes, ch15 is never reached.
        drain();
        clear_counts();
        chan_mask = 16'h8001; dwell = 8'd4; continuous = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_enable("stop_seq_enable_seen");
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (10) step();
        cmp_int("stop_seq_enable_cycles", en_cnt, 4);
        cmp_int("stop_seq_pass_done", pd_cnt, 0);
        cmp_int("stop_seq_ch15_driven", int'(ch15_driven), 0);
        cmp_int("stop_seq_busy_end", int'(busy === 1'b1), 0);

        // Asynchronous reset in the middle of a DRIVE.
        drain();
        chan_mask = 16'hFFFF; dwell = 8'd5; continuous = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_enable("reset_seq_enable_seen");
        step();
        #2 reset_n = 1'b0;
        #1;
        cmp_int("async_reset_outputs", int'({binary_out, enable_out, chan_strobe, pass_done, busy}), 0);
        q.delete();
        cur = idle_rec(4'd0);
        pass_stb = 0;
        @(negedge clk);
        repeat (2) step();
        reset_n = 1'b1;
        clear_counts();
        repeat (10) step();
        cmp_int("post_reset_enable_cycles", en_cnt, 0);
        cmp_int("post_reset_busy", int'(busy === 1'b1), 0);

        // Randomized traffic against the trace model.
        for (int c = 0; c < 2500; c++) begin
            start      = ($urandom_range(0, 15) == 0);
            stop       = ($urandom_range(0, 59) == 0);
            dwell      = 8'($urandom_range(0, 4));
            continuous = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) chan_mask = rand_mask();
            step();
        end
        start = 1'b0;
        stop  = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
